// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the program counter block
package pc_pkg;

  // Widest program counter the helper arithmetic supports.
  localparam int unsigned PC_MAX_W = 32;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_JMP,
    PC_CALL,
    PC_RET
  } pc_sel_t;

  // Relative-jump adder. The low D bits of a plain add are the modulo-2^D
  // result whether or not the offset was sign-extended, so callers
  // zero-extend both operands and cast the result back to D bits.
  function automatic logic [PC_MAX_W-1:0] next_rel(input logic [PC_MAX_W-1:0] pc,
                                                   input logic [PC_MAX_W-1:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - LIFO return-address stack with full/empty and error pulses
module ret_stack #(
  parameter int unsigned D      = 12,
  parameter int unsigned SDEPTH = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [D-1:0] push_data_i,
  output logic [D-1:0] top_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam int unsigned CW = $clog2(SDEPTH + 1);
  localparam int unsigned AW = $clog2(SDEPTH);

  logic [CW-1:0] count_q, count_d;
  logic [D-1:0]  mem_q [SDEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(SDEPTH));
  assign empty_o = (count_q == '0);

  // A pop always wins over a simultaneous push; the push is silently dropped.
  assign do_pop      = pop_i & ~empty_o;
  assign do_push     = push_i & ~pop_i & ~full_o;
  assign overflow_o  = push_i & ~pop_i & full_o;
  assign underflow_o = pop_i & empty_o;

  // Top entry sits one below the count; its value is meaningless when empty.
  assign top_o = mem_q[AW'(count_q - CW'(1))];

  // Next occupancy count.
  always_comb begin
    count_d = count_q;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Occupancy register; contents are left untouched by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage write at the current count slot.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[AW'(count_q)] <= push_data_i;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - fetch program counter with jumps, stall and call/return stack
module pc_stack
  import pc_pkg::*;
#(
  parameter int unsigned D        = 12,
  parameter int unsigned SDEPTH   = 4,
  parameter logic [D-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         jump_en,
  input  logic         jump_rel,
  input  logic [D-1:0] target,
  input  logic         call_en,
  input  logic         ret_en,
  output logic [D-1:0] prog_ctr,
  output logic         stack_full,
  output logic         stack_empty,
  output logic         stack_err
);

  pc_sel_t      sel;
  logic [D-1:0] prog_ctr_q, prog_ctr_d;
  logic [D-1:0] pc_inc, jmp_dest, stk_top;
  logic         err_q, err_d;
  logic         push, pop, ovf, udf;

  assign pc_inc   = prog_ctr_q + D'(1);
  assign jmp_dest = jump_rel ? D'(next_rel(PC_MAX_W'(prog_ctr_q), PC_MAX_W'(target)))
                             : target;

  // Priority decode of the control inputs; reset is handled in the registers.
  always_comb begin
    sel = PC_INC;
    if (stall) begin
      sel = PC_HOLD;
    end else if (ret_en) begin
      sel = PC_RET;
    end else if (call_en) begin
      sel = PC_CALL;
    end else if (jump_en) begin
      sel = PC_JMP;
    end
  end

  // Next program counter, stack requests and sticky error.
  always_comb begin
    prog_ctr_d = prog_ctr_q;
    push       = 1'b0;
    pop        = 1'b0;
    case (sel)
      PC_HOLD: prog_ctr_d = prog_ctr_q;
      PC_INC:  prog_ctr_d = pc_inc;
      PC_JMP:  prog_ctr_d = jmp_dest;
      PC_CALL: begin
        prog_ctr_d = jmp_dest;
        push       = 1'b1;
      end
      PC_RET: begin
        pop        = 1'b1;
        prog_ctr_d = stack_empty ? pc_inc : stk_top;
      end
      default: prog_ctr_d = prog_ctr_q;
    endcase
    err_d = err_q | ovf | udf;
  end

  // Program counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr_q <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      prog_ctr_q <= prog_ctr_d;
      err_q      <= err_d;
    end
  end

  ret_stack #(
    .D      (D),
    .SDEPTH (SDEPTH)
  ) u_ret_stack (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_inc),
    .top_o       (stk_top),
    .full_o      (stack_full),
    .empty_o     (stack_empty),
    .overflow_o  (ovf),
    .underflow_o (udf)
  );

  assign prog_ctr  = prog_ctr_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - scoreboard bench for pc_stack with directed vectors
module tb_pc_stack;

  logic        clk = 1'b0;
  logic        reset, stall, jump_en, jump_rel, call_en, ret_en;
  logic [11:0] target;
  logic [11:0] prog_ctr;
  logic        stack_full, stack_empty, stack_err;

  typedef struct {
    int          cyc;
    logic [11:0] pc;
    logic        full;
    logic        empty;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt  = 0;
  int   checks   = 0;
  int   failures = 0;

  pc_stack #(
    .D        (12),
    .SDEPTH   (4),
    .RESET_PC (12'h000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_rel    (jump_rel),
    .target      (target),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .prog_ctr    (prog_ctr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compare the outputs each cycle against the entry due now.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc_cnt) begin
        failures++;
        $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.name, cyc_cnt, e.cyc);
      end else if ({prog_ctr, stack_full, stack_empty, stack_err} !==
                   {e.pc, e.full, e.empty, e.err}) begin
        failures++;
        $display("FAIL %s: got pc=%h full=%b empty=%b err=%b, required pc=%h full=%b empty=%b err=%b",
                 e.name, prog_ctr, stack_full, stack_empty, stack_err,
                 e.pc, e.full, e.empty, e.err);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs required after the edge.
  task automatic step(input logic rst, input logic st, input logic je, input logic jr,
                      input logic ce, input logic re, input logic [11:0] tgt,
                      input logic [11:0] epc, input logic ef, input logic ee,
                      input logic eerr, input string nm);
    exp_t e;
    reset    = rst;
    stall    = st;
    jump_en  = je;
    jump_rel = jr;
    call_en  = ce;
    ret_en   = re;
    target   = tgt;
    e.cyc    = cyc_cnt + 1;
    e.pc     = epc;
    e.full   = ef;
    e.empty  = ee;
    e.err    = eerr;
    e.name   = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_rel = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; target = 12'h000;
    @(posedge clk);
    #1;
    //    rst st je jr ce re  tgt      pc    f  e  err
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 0, "reset");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 1, 0, "inc1");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h002, 0, 1, 0, "inc2");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h003, 0, 1, 0, "inc3");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h004, 0, 1, 0, "inc4");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h005, 0, 1, 0, "inc5");
    step(0, 0, 1, 0, 0, 0, 12'h010, 12'h010, 0, 1, 0, "jmp_abs_010");
    step(0, 0, 1, 1, 0, 0, 12'hFFC, 12'h00C, 0, 1, 0, "jmp_rel_neg4");
    step(0, 0, 1, 0, 0, 0, 12'h3A0, 12'h3A0, 0, 1, 0, "jmp_abs_3a0");
    step(0, 0, 1, 0, 0, 0, 12'hFFF, 12'hFFF, 0, 1, 0, "jmp_abs_fff");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 0, "inc_wrap");
    step(0, 0, 1, 0, 0, 0, 12'h020, 12'h020, 0, 1, 0, "jmp_abs_020");
    step(0, 0, 1, 0, 1, 0, 12'h100, 12'h100, 0, 0, 0, "call_100");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h101, 0, 0, 0, "sub_inc1");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h102, 0, 0, 0, "sub_inc2");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h021, 0, 1, 0, "ret_021");
    step(0, 0, 0, 0, 1, 0, 12'h200, 12'h200, 0, 0, 0, "call1_abs");
    step(0, 0, 0, 1, 1, 0, 12'h005, 12'h205, 0, 0, 0, "call2_rel");
    step(0, 0, 0, 0, 1, 0, 12'h300, 12'h300, 0, 0, 0, "call3_abs");
    step(0, 0, 0, 1, 1, 0, 12'hFFE, 12'h2FE, 1, 0, 0, "call4_full");
    step(0, 0, 0, 0, 1, 0, 12'h400, 12'h400, 1, 0, 1, "call5_ovf");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h301, 0, 0, 1, "ret1");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h206, 0, 0, 1, "ret2");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h201, 0, 0, 1, "ret3");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h022, 0, 1, 1, "ret4");
    step(0, 0, 0, 0, 0, 1, 12'h000, 12'h023, 0, 1, 1, "ret5_udf");
    step(0, 0, 0, 0, 1, 0, 12'h500, 12'h500, 0, 0, 1, "call_500");
    step(0, 1, 1, 0, 0, 0, 12'h123, 12'h500, 0, 0, 1, "stall_jmp");
    step(0, 1, 0, 1, 1, 0, 12'h123, 12'h500, 0, 0, 1, "stall_call");
    step(0, 1, 1, 0, 1, 1, 12'h123, 12'h500, 0, 0, 1, "stall_all");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h501, 0, 0, 1, "stall_release");
    step(1, 0, 0, 0, 0, 0, 12'h000, 12'h000, 0, 1, 0, "reset2");
    step(0, 0, 0, 0, 1, 0, 12'h040, 12'h040, 0, 0, 0, "call_040");
    step(0, 0, 0, 0, 1, 1, 12'h777, 12'h001, 0, 1, 0, "call_ret_same");
    step(0, 0, 0, 0, 1, 0, 12'h050, 12'h050, 0, 0, 0, "call_050");
    step(1, 0, 0, 0, 1, 0, 12'h060, 12'h000, 0, 1, 0, "reset_with_call");
    step(0, 0, 0, 0, 0, 0, 12'h000, 12'h001, 0, 1, 0, "post_reset_inc");
    reset = 1'b0; stall = 1'b0; jump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Next-generation program counter for the core fetch stage.
- Width is parametrised. Supports absolute and PC-relative (signed offset) jumps.
- Adds a stall input and a hardware return-address stack for call/return, with full/empty status and sticky error flags.
- Drives the instruction-memory address every cycle.

Parameters:
- D, 12, program counter width in bits; the address space is 2^D words.
- SDEPTH, 4, return-stack depth in entries (must be >= 2).
- RESET_PC, 0, value loaded into prog_ctr on reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold: prog_ctr, stack and flags keep their values.
- jump_en  input  1  take a branch/jump this cycle.
- jump_rel  input  1  1 = relative (prog_ctr + signed target); 0 = absolute (target). Applies to jumps and calls.
- target  input  D  absolute address, or two's-complement offset.
- call_en  input  1  call: push the return address, then jump per jump_rel/target.
- ret_en  input  1  return: pop the return address into prog_ctr.
- prog_ctr  output  D  current program counter.
- stack_full  output  1  high when the stack holds SDEPTH entries.
- stack_empty  output  1  high when the stack holds 0 entries.
- stack_err  output  1  sticky: set on overflow or underflow, cleared only by reset.

Behaviour:
- All outputs are registered or derived from registers; there is no combinational path from inputs to outputs.
- Reset: prog_ctr=RESET_PC, stack count=0, stack_empty=1, stack_full=0, stack_err=0. Stack data contents are don't-care. Reset mid-stall or mid-call wins unconditionally.
- Per-cycle priority: reset > stall > ret_en > call_en > jump_en > increment.
- Increment: prog_ctr <= prog_ctr + 1, wrapping from 2^D-1 to 0.
- Jump, absolute: prog_ctr <= target.
- Jump, relative: prog_ctr <= prog_ctr + target. The add is D-bit modulo 2^D, with target sign-interpreted. Example (D=12): target=12'hFFF means -1.
- Call, stack not full:
  - push (prog_ctr + 1) mod 2^D and increment count;
  - prog_ctr <= jump destination (absolute or relative per jump_rel).
  - jump_en is ignored while call_en is high.
- Call, stack full: the jump is still taken, the push is discarded, count is unchanged, stack_err <= 1.
- Return, stack not empty: prog_ctr <= top entry; decrement count.
- Return, stack empty: prog_ctr increments normally, count stays 0, stack_err <= 1.
- ret_en and call_en together: only the return executes; the call is dropped and no error is raised.
- Stall: no state changes; all inputs are ignored except reset.
- Latency: one cycle; the new prog_ctr is visible the cycle after the control input.
- stack_full and stack_empty reflect the registered count (count==SDEPTH and count==0 respectively).
- Stack is LIFO: the top is the most recent push; a push then a pop returns the same value.

Decomposition:
- Package pc_pkg holds:
  - typedef enum logic [2:0] pc_sel_t {PC_HOLD, PC_INC, PC_JMP, PC_CALL, PC_RET};
  - function next_rel(pc, off) for the modulo-2^D signed add.
- Sub-module ret_stack #(D, SDEPTH), a LIFO:
  - inputs: push, pop, push_data;
  - outputs: top, full, empty, plus overflow/underflow pulses;
  - count register width $clog2(SDEPTH+1).
- pc_stack contains the priority decode to pc_sel_t, the prog_ctr register and the sticky error flag.

Test Plan:
- Reset then 5 idle cycles (RESET_PC=0) -> prog_ctr 0,1,2,3,4,5; stack_empty=1; stack_err=0.
- prog_ctr=12'h010: jump_en=1, jump_rel=1, target=12'hFFC -> next 12'h00C. Then jump_rel=0, target=12'h3A0 -> 12'h3A0. Increment at 12'hFFF -> 12'h000.
- prog_ctr=12'h020: call_en, absolute target 12'h100 -> prog_ctr=12'h100, stack top=12'h021. Two increments, then ret_en -> prog_ctr=12'h021, stack_empty=1.
- Five consecutive calls (SDEPTH=4) -> stack_full after the 4th; 5th still jumps, stack_err=1. Four returns yield the pushed addresses in reverse order. A 5th return increments prog_ctr, stack_err remains 1.
- stall=1 for 3 cycles with jump_en/call_en/ret_en toggling -> prog_ctr, count and flags unchanged. Release -> normal increment resumes.
- call_en and ret_en together with a non-empty stack -> pop only, no push, no error. Assert reset in the same cycle as a call -> prog_ctr=RESET_PC, count=0, stack_err=0.
